// File: rtl/ula_pkg.sv
// Shared types and constants for the keypad-driven add/subtract sequencer
// and its 8-bit signed ALU.
package ula_pkg;
   localparam int W = 8;

   typedef enum logic [2:0] {S_A, S_OP, S_B, S_EXEC, S_SHOW} state_t;

   localparam logic [1:0] KEY_OPND = 2'b00;
   localparam logic [1:0] KEY_OPER = 2'b01;
   localparam logic [1:0] KEY_EQ   = 2'b10;
   localparam logic [1:0] KEY_CLR  = 2'b11;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/ula.sv
// Combinational 8-bit signed add/subtract unit: result = data_y +/- data_x,
// with true signed overflow.
module ula
   import ula_pkg::*;
(
   input  logic signed [W-1:0] data_y,
   input  logic signed [W-1:0] data_x,
   input  logic                tula,
   output logic signed [W-1:0] result,
   output logic                ovf
);
   logic [W:0] ext;

   always_comb begin
      ext = '0;
      if (tula == OP_SUB) ext = {data_y[W-1], data_y} - {data_x[W-1], data_x};
      else                ext = {data_y[W-1], data_y} + {data_x[W-1], data_x};
      result = ext[W-1:0];
      // Sign-extended sum disagrees with its truncation exactly on overflow.
      ovf    = ext[W] ^ ext[W-1];
   end
endmodule

// File: rtl/ula_ctrl.sv
// Pocket-calculator sequencer: collects A, operator and B from decoded keys,
// fires the ula on equals and registers result, overflow and status pulses.
module ula_ctrl
   import ula_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                key_valid,
   input  logic [1:0]          key_kind,
   input  logic [W-1:0]        key_data,
   output logic signed [W-1:0] disp,
   output logic                ovf,
   output logic                res_valid,
   output logic                err
);
   state_t             state_q, state_d;
   logic signed [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, disp_q, disp_d;
   logic               op_q, op_d, ovf_q, ovf_d, res_valid_q, res_valid_d, err_q, err_d;
   logic signed [W-1:0] ula_res;
   logic               ula_ovf;

   ula u_ula (
      .data_y (a_q),
      .data_x (b_q),
      .tula   (op_q),
      .result (ula_res),
      .ovf    (ula_ovf)
   );

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      res_d       = res_q;
      disp_d      = disp_q;
      ovf_d       = ovf_q;
      res_valid_d = 1'b0;
      err_d       = 1'b0;
      if (key_valid) begin
         if (key_kind == KEY_CLR) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = OP_ADD;
            res_d   = '0;
            disp_d  = '0;
            ovf_d   = 1'b0;
         end else if (key_kind == KEY_OPND && state_q != S_SHOW) begin
            disp_d = key_data;
            ovf_d  = 1'b0;
            case (state_q)
               S_A, S_OP: begin a_d = key_data; state_d = S_OP; end
               default:   begin b_d = key_data; state_d = S_EXEC; end
            endcase
         end else begin
            case (state_q)
               S_OP, S_B: begin
                  if (key_kind == KEY_OPER) begin
                     op_d    = key_data[0];
                     state_d = S_B;
                  end else err_d = 1'b1;
               end
               S_EXEC: begin
                  if (key_kind == KEY_EQ) begin
                     // A also takes the result so a repeated equals computes res op B.
                     a_d         = ula_res;
                     res_d       = ula_res;
                     disp_d      = ula_res;
                     ovf_d       = ula_ovf;
                     res_valid_d = 1'b1;
                     state_d     = S_SHOW;
                  end else err_d = 1'b1;
               end
               S_SHOW: begin
                  if (key_kind == KEY_OPND) begin
                     a_d     = key_data;
                     disp_d  = key_data;
                     ovf_d   = 1'b0;
                     state_d = S_OP;
                  end else if (key_kind == KEY_OPER) begin
                     a_d     = res_q;
                     op_d    = key_data[0];
                     state_d = S_B;
                  end else begin
                     a_d         = ula_res;
                     res_d       = ula_res;
                     disp_d      = ula_res;
                     ovf_d       = ula_ovf;
                     res_valid_d = 1'b1;
                  end
               end
               default: err_d = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_A;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= OP_ADD;
         res_q       <= '0;
         disp_q      <= '0;
         ovf_q       <= 1'b0;
         res_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         res_q       <= res_d;
         disp_q      <= disp_d;
         ovf_q       <= ovf_d;
         res_valid_q <= res_valid_d;
         err_q       <= err_d;
      end
   end

   assign disp      = disp_q;
   assign ovf       = ovf_q;
   assign res_valid = res_valid_q;
   assign err       = err_q;
endmodule

// File: tb/tb_ula_ctrl.sv
// Directed vector bench for ula_ctrl: one key per cycle, outputs checked
// one cycle later against hand-computed values.
module tb_ula_ctrl;
   import ula_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              key_valid;
   logic [1:0]        key_kind;
   logic [7:0]        key_data;
   logic signed [7:0] disp;
   logic              ovf, res_valid, err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst;
      logic       kv;
      logic [1:0] kind;
      logic [7:0] data;
      logic [7:0] e_disp;
      logic       e_ovf;
      logic       e_rv;
      logic       e_err;
   } vec_t;

   vec_t vecs[$];

   ula_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_kind  (key_kind),
      .key_data  (key_data),
      .disp      (disp),
      .ovf       (ovf),
      .res_valid (res_valid),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got 0x%02h expected 0x%02h", name, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      rst       = v.rst;
      key_valid = v.kv;
      key_kind  = v.kind;
      key_data  = v.data;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      key_valid = 1'b0;
      chk("disp",      idx, disp,             v.e_disp);
      chk("ovf",       idx, {7'd0, ovf},       {7'd0, v.e_ovf});
      chk("res_valid", idx, {7'd0, res_valid}, {7'd0, v.e_rv});
      chk("err",       idx, {7'd0, err},       {7'd0, v.e_err});
   endtask

   function automatic vec_t k(input logic [1:0] kind, input logic [7:0] data,
                              input logic [7:0] d, input logic o, input logic rv, input logic e);
      vec_t v;
      v = '{1'b0, 1'b1, kind, data, d, o, rv, e};
      return v;
   endfunction

   initial begin
      rst = 1'b1; key_valid = 1'b0; key_kind = 2'b00; key_data = 8'h00;
      repeat (2) @(posedge clk);
      #1;

      vecs.push_back('{1'b1, 1'b0, KEY_OPND, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
      // add with overflow: 100 + 50
      vecs.push_back(k(KEY_OPND, 8'd100, 8'd100, 0, 0, 0));
      vecs.push_back(k(KEY_OPER, 8'd0,   8'd100, 0, 0, 0));
      vecs.push_back(k(KEY_OPND, 8'd50,  8'd50,  0, 0, 0));
      vecs.push_back(k(KEY_EQ,   8'd0,   8'h96,  1, 1, 0));
      vecs.push_back('{1'b0, 1'b0, KEY_OPND, 8'h00, 8'h96, 1'b1, 1'b0, 1'b0});
      // subtract: 5 - 7, then -128 - 1
      vecs.push_back(k(KEY_OPND, 8'd5,   8'd5,   0, 0, 0));
      vecs.push_back(k(KEY_OPER, 8'd1,   8'd5,   0, 0, 0));
      vecs.push_back(k(KEY_OPND, 8'd7,   8'd7,   0, 0, 0));
      vecs.push_back(k(KEY_EQ,   8'd0,   8'hFE,  0, 1, 0));
      vecs.push_back(k(KEY_OPND, 8'h80,  8'h80,  0, 0, 0));
      vecs.push_back(k(KEY_OPER, 8'd1,   8'h80,  0, 0, 0));
      vecs.push_back(k(KEY_OPND, 8'd1,   8'd1,   0, 0, 0));
      vecs.push_back(k(KEY_EQ,   8'd0,   8'd127, 1, 1, 0));
      vecs.push_back(k(KEY_CLR,  8'd0,   8'd0,   0, 0, 0));
      // illegal keys in S_A
      vecs.push_back(k(KEY_EQ,   8'd0,   8'd0,   0, 0, 1));
      vecs.push_back(k(KEY_OPER, 8'd1,   8'd0,   0, 0, 1));
      // chain and repeat: 10+3=13, -4=9, =5, =1
      vecs.push_back(k(KEY_OPND, 8'd10,  8'd10,  0, 0, 0));
      vecs.push_back(k(KEY_OPER, 8'd0,   8'd10,  0, 0, 0));
      vecs.push_back(k(KEY_OPND, 8'd3,   8'd3,   0, 0, 0));
      vecs.push_back(k(KEY_EQ,   8'd0,   8'd13,  0, 1, 0));
      vecs.push_back(k(KEY_OPER, 8'd1,   8'd13,  0, 0, 0));
      vecs.push_back(k(KEY_OPND, 8'd4,   8'd4,   0, 0, 0));
      vecs.push_back(k(KEY_EQ,   8'd0,   8'd9,   0, 1, 0));
      vecs.push_back(k(KEY_EQ,   8'd0,   8'd5,   0, 1, 0));
      vecs.push_back(k(KEY_EQ,   8'd0,   8'd1,   0, 1, 0));
      vecs.push_back('{1'b0, 1'b0, KEY_OPND, 8'h00, 8'd1, 1'b0, 1'b0, 1'b0});
      // operator in S_EXEC is illegal; equals still 20+30
      vecs.push_back(k(KEY_OPND, 8'd20,  8'd20,  0, 0, 0));
      vecs.push_back(k(KEY_OPER, 8'd0,   8'd20,  0, 0, 0));
      vecs.push_back(k(KEY_OPND, 8'd30,  8'd30,  0, 0, 0));
      vecs.push_back(k(KEY_OPER, 8'd1,   8'd30,  0, 0, 1));
      vecs.push_back(k(KEY_EQ,   8'd0,   8'd50,  0, 1, 0));
      // replacement: A 1->60, op add->sub, B 2->70: 60-70
      vecs.push_back(k(KEY_CLR,  8'd0,   8'd0,   0, 0, 0));
      vecs.push_back(k(KEY_OPND, 8'd1,   8'd1,   0, 0, 0));
      vecs.push_back(k(KEY_OPND, 8'd60,  8'd60,  0, 0, 0));
      vecs.push_back(k(KEY_OPER, 8'd0,   8'd60,  0, 0, 0));
      vecs.push_back(k(KEY_OPER, 8'd1,   8'd60,  0, 0, 0));
      vecs.push_back(k(KEY_OPND, 8'd2,   8'd2,   0, 0, 0));
      vecs.push_back(k(KEY_OPND, 8'd70,  8'd70,  0, 0, 0));
      vecs.push_back(k(KEY_EQ,   8'd0,   8'hF6,  0, 1, 0));
      // clear in S_EXEC returns to S_A without err
      vecs.push_back(k(KEY_OPND, 8'd5,   8'd5,   0, 0, 0));
      vecs.push_back(k(KEY_OPER, 8'd0,   8'd5,   0, 0, 0));
      vecs.push_back(k(KEY_OPND, 8'd6,   8'd6,   0, 0, 0));
      vecs.push_back(k(KEY_CLR,  8'd0,   8'd0,   0, 0, 0));
      vecs.push_back(k(KEY_EQ,   8'd0,   8'd0,   0, 0, 1));
      // reset wins over an equals key in the same cycle
      vecs.push_back(k(KEY_OPND, 8'd9,   8'd9,   0, 0, 0));
      vecs.push_back(k(KEY_OPER, 8'd0,   8'd9,   0, 0, 0));
      vecs.push_back(k(KEY_OPND, 8'd9,   8'd9,   0, 0, 0));
      vecs.push_back('{1'b1, 1'b1, KEY_EQ, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
      vecs.push_back(k(KEY_EQ,   8'd0,   8'd0,   0, 0, 1));
      // key data without key_valid is ignored
      vecs.push_back('{1'b0, 1'b0, KEY_OPND, 8'd55, 8'd0, 1'b0, 1'b0, 1'b0});
      // negative overflow: -100 + -100, then a new operand clears ovf
      vecs.push_back(k(KEY_OPND, 8'h9C,  8'h9C,  0, 0, 0));
      vecs.push_back(k(KEY_OPER, 8'd0,   8'h9C,  0, 0, 0));
      vecs.push_back(k(KEY_OPND, 8'h9C,  8'h9C,  0, 0, 0));
      vecs.push_back(k(KEY_EQ,   8'd0,   8'h38,  1, 1, 0));
      vecs.push_back(k(KEY_OPND, 8'd3,   8'd3,   0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // Back-to-back equals: 3-1=2, then 1, then 0, each its own pulse,
      // followed by idle cycles where res_valid must stay low.
      apply(k(KEY_OPER, 8'd1, 8'd3, 0, 0, 0), 100);
      apply(k(KEY_OPND, 8'd1, 8'd1, 0, 0, 0), 101);
      for (int j = 0; j < 3; j++) begin
         apply(k(KEY_EQ, 8'd0, 8'(2 - j), 0, 1, 0), 102 + j);
      end
      for (int j = 0; j < 3; j++) begin
         @(posedge clk);
         #1;
         chk("idle_res_valid", 110 + j, {7'd0, res_valid}, 8'd0);
         chk("idle_disp",      110 + j, disp,             8'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ula_ctrl.md
# ula_ctrl

Sequencer that turns decoded keypad events into add/subtract operations on the shared 8-bit signed `ula` datapath. It sits between the keyboard decoder and the display driver. It collects operand A, an operator and operand B, fires the ALU on the equals key, then registers the result and the overflow flag. Results can be chained and repeated like a pocket calculator.

## Interface
Parameters: none (the width is fixed at 8-bit signed to match `ula`).

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  one-cycle strobe: a decoded key is present this cycle.
- `key_kind`  in  2  key class: 00 operand, 01 operator, 10 equals, 11 clear.
- `key_data`  in  8  signed operand value when the kind is operand; bit 0 is the operator code when the kind is operator (0 add, 1 sub).
- `disp`  out  8  signed value to display: the last entered operand or the last result.
- `ovf`  out  1  overflow flag of the last result; cleared when a new operand is entered.
- `res_valid`  out  1  one-cycle pulse when a new result is registered.
- `err`  out  1  one-cycle pulse when a key is illegal for the current state.

## Operation
- Registers: A[7:0], B[7:0], op, res[7:0], ovf, and the state.
- Embedded `ula` wiring: `data_y`=A, `data_x`=B, `tula`=op. Sub therefore computes A−B.
- Arithmetic: the result wraps to 8 bits. `ovf` is true signed overflow, i.e. the exact result is outside −128..127.
- States:
  - S_A: waiting for the first operand.
  - S_OP: waiting for an operator.
  - S_B: waiting for the second operand.
  - S_EXEC: waiting for equals.
  - S_SHOW: a result is shown.
- Transitions. A key applies only when `key_valid`=1; keys without `key_valid` are ignored.
  - S_A: operand → A=data, disp=data, ovf=0, go to S_OP. Operator or equals → `err`, stay.
  - S_OP: operator → op=data[0], go to S_B. Operand → replace A and disp, stay. Equals → `err`.
  - S_B: operand → B=data, disp=data, go to S_EXEC. Operator → replace op, stay. Equals → `err`.
  - S_EXEC: equals → res/ovf from `ula`, disp=result, `res_valid`, go to S_SHOW. Operand → replace B and disp, stay. Operator → `err`.
  - S_SHOW:
    - Operand → A=data, disp=data, ovf=0, go to S_OP.
    - Operator → A=res, op=data[0], go to S_B (chaining).
    - Equals → A=res, recompute with the same B and op, `res_valid`, stay (repeat).
  - Any state, clear → all registers 0, go to S_A. Clear never raises `err`.
- `err` leaves all other registers unchanged.

## Timing
- Reset values: state=S_A; A=B=res=0; op=0; `disp`=0; `ovf`=0; `res_valid`=0; `err`=0.
- Reset takes priority over any key in the same cycle.
- Exactly one key per cycle. The block is always ready and has no backpressure.
- All outputs are registered. A key sampled at edge N is reflected on the outputs after edge N.
- Result latency: an equals key at edge N gives `disp`, `ovf` and `res_valid`=1 during cycle N+1. `res_valid` is 1 for that one cycle only.
- Back-to-back equals in S_SHOW produces one `res_valid` pulse per key. Each pulse uses the result of the previous key.
- Reset or clear in the middle of a sequence aborts it with no `res_valid` pulse.

## Structure
- Shared package `ula_pkg`: the state enum (S_A, S_OP, S_B, S_EXEC, S_SHOW), the key-kind constants (KEY_OPND, KEY_OPER, KEY_EQ, KEY_CLR), the op constants (OP_ADD=0, OP_SUB=1) and the width constant W=8.
- One sub-module: the existing `ula`, instantiated once and driven by the registered A, B and op. No other hierarchy.

## Test plan
- Add: reset, then keys 100, op add, 50, equals → `disp`=−106 (0x96), `ovf`=1, a single `res_valid` pulse one cycle after equals.
- Subtract: keys 5, op sub, 7, equals → `disp`=−2, `ovf`=0. Then −128, op sub, 1, equals → `disp`=127, `ovf`=1.
- Chain and repeat: 10, add, 3, equals (13); then sub, 4, equals → 9; then equals twice → 5, then 1. Each step gives one `res_valid` pulse.
- Illegal keys:
  - Equals in S_A → `err` pulse, `disp` unchanged.
  - Operator in S_A → `err`.
  - Operator in S_EXEC → `err`, and a following equals still computes correctly.
- Clear and reset: clear in S_EXEC → outputs 0, state S_A, no `err`. `rst` asserted in the same cycle as an equals key → all outputs at reset values, no `res_valid`.
- Replacement: in S_OP a new operand replaces A; in S_B a new operator replaces op; in S_EXEC a new operand replaces B. Equals then uses the latest values.
